// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_lock_sequencer_pkg;

  // Width of the PLL dynamic delay bus.
  localparam int DELAY_W = 8;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Counter width for a terminal count of n; at least one bit so n=1 still works.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL control and dynamic-delay request bundle; master = sequencer, slave = PLL/core side.
interface pll_lock_sequencer_if;
  import pll_lock_sequencer_pkg::*;

  logic               PLL_LOCK;
  logic               PLL_RESETB;
  logic               PLL_BYPASS;
  logic               PLL_LATCHINPUTVALUE;
  logic [DELAY_W-1:0] PLL_DYNAMICDELAY;
  logic               DELAY_REQ;
  logic [DELAY_W-1:0] DELAY_DATA;
  logic               DELAY_ACK;
  logic               SYS_RESET;
  logic               LOCKED;
  logic               FAILED;

  modport master (
    input  PLL_LOCK, DELAY_REQ, DELAY_DATA,
    output PLL_RESETB, PLL_BYPASS, PLL_LATCHINPUTVALUE, PLL_DYNAMICDELAY,
           DELAY_ACK, SYS_RESET, LOCKED, FAILED
  );

  modport slave (
    output PLL_LOCK, DELAY_REQ, DELAY_DATA,
    input  PLL_RESETB, PLL_BYPASS, PLL_LATCHINPUTVALUE, PLL_DYNAMICDELAY,
           DELAY_ACK, SYS_RESET, LOCKED, FAILED
  );

endinterface

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; clears to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Capture the async input, then retime once more to settle metastability.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies LOCK, releases core reset,
// re-sequences on lock loss or delay change, falls back to bypass after repeated failures.
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int                 RESET_CYCLES        = 16,
  parameter int                 LOCK_STABLE_CYCLES  = 256,
  parameter int                 LOCK_TIMEOUT_CYCLES = 65536,
  parameter int                 MAX_RETRIES         = 4,
  parameter logic [DELAY_W-1:0] DELAY_INIT          = 8'h00
) (
  input logic                  REFERENCECLK,
  input logic                  RESETB,
  pll_lock_sequencer_if.master bus
);

  localparam int RST_W = cnt_w(RESET_CYCLES);
  localparam int STB_W = cnt_w(LOCK_STABLE_CYCLES);
  localparam int TO_W  = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int RTY_W = cnt_w(MAX_RETRIES);

  logic w_lock;

  state_t             r_state;
  logic               r_pll_resetb;
  logic               r_pll_bypass;
  logic [DELAY_W-1:0] r_delay;
  logic               r_delay_ack;
  logic               r_sys_reset;
  logic               r_locked;
  logic               r_failed;
  logic [RST_W-1:0]   r_rst_cnt;
  logic [STB_W-1:0]   r_stable_cnt;
  logic [TO_W-1:0]    r_timeout_cnt;
  logic [RTY_W-1:0]   r_retries;
  logic               r_lock_low;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (REFERENCECLK),
    .i_rst_n (RESETB),
    .i_d     (bus.PLL_LOCK),
    .o_q     (w_lock)
  );

  // Sequencer FSM; counters stop at their terminal value because every terminal
  // count causes a state change, so none of them can wrap.
  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      r_state       <= ST_RESET_PLL;
      r_pll_resetb  <= 1'b0;
      r_pll_bypass  <= 1'b0;
      r_delay       <= DELAY_INIT;
      r_delay_ack   <= 1'b0;
      r_sys_reset   <= 1'b1;
      r_locked      <= 1'b0;
      r_failed      <= 1'b0;
      r_rst_cnt     <= '0;
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_retries     <= '0;
      r_lock_low    <= 1'b0;
    end else begin
      r_delay_ack <= 1'b0;
      case (r_state)
        ST_RESET_PLL: begin
          if (r_rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
            r_pll_resetb  <= 1'b1;
            r_timeout_cnt <= '0;
            r_stable_cnt  <= '0;
            r_state       <= ST_WAIT_LOCK;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK, ST_STABLE: begin
          if (r_timeout_cnt == TO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            if ((int'(r_retries) + 1) < MAX_RETRIES) begin
              r_retries    <= r_retries + 1'b1;
              r_pll_resetb <= 1'b0;
              r_rst_cnt    <= '0;
              r_state      <= ST_RESET_PLL;
            end else begin
              // Give up: run the core straight off the bypassed reference.
              r_pll_bypass <= 1'b1;
              r_pll_resetb <= 1'b0;
              r_sys_reset  <= 1'b0;
              r_failed     <= 1'b1;
              r_locked     <= 1'b0;
              r_state      <= ST_FAIL;
            end
          end else begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
            if (r_state == ST_WAIT_LOCK) begin
              if (w_lock) r_state <= ST_STABLE;
            end else if (!w_lock) begin
              r_stable_cnt <= '0;
              r_state      <= ST_WAIT_LOCK;
            end else if (r_stable_cnt == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
              r_sys_reset <= 1'b0;
              r_locked    <= 1'b1;
              r_lock_low  <= 1'b0;
              r_state     <= ST_RUN;
            end else begin
              r_stable_cnt <= r_stable_cnt + 1'b1;
            end
          end
        end

        ST_RUN: begin
          r_lock_low <= !w_lock;
          if (!w_lock && r_lock_low) begin
            // Second consecutive low: genuine lock loss, start over with fresh retries.
            r_sys_reset  <= 1'b1;
            r_locked     <= 1'b0;
            r_retries    <= '0;
            r_pll_resetb <= 1'b0;
            r_rst_cnt    <= '0;
            r_state      <= ST_RESET_PLL;
          end else if (w_lock && bus.DELAY_REQ) begin
            // Only accept a new delay while lock is clean; a pending loss takes priority.
            r_delay_ack  <= 1'b1;
            r_delay      <= bus.DELAY_DATA;
            r_sys_reset  <= 1'b1;
            r_locked     <= 1'b0;
            r_retries    <= '0;
            r_pll_resetb <= 1'b0;
            r_rst_cnt    <= '0;
            r_state      <= ST_RESET_PLL;
          end
        end

        ST_FAIL: begin
          r_state <= ST_FAIL;
        end

        default: begin
          r_pll_resetb <= 1'b0;
          r_rst_cnt    <= '0;
          r_state      <= ST_RESET_PLL;
        end
      endcase
    end
  end

  assign bus.PLL_RESETB          = r_pll_resetb;
  assign bus.PLL_BYPASS          = r_pll_bypass;
  assign bus.PLL_LATCHINPUTVALUE = 1'b0;
  assign bus.PLL_DYNAMICDELAY    = r_delay;
  assign bus.DELAY_ACK           = r_delay_ack;
  assign bus.SYS_RESET           = r_sys_reset;
  assign bus.LOCKED              = r_locked;
  assign bus.FAILED              = r_failed;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

  localparam int RC  = 4;
  localparam int LSC = 8;
  localparam int LTO = 64;
  localparam int MR  = 2;

  typedef struct {
    string name;
    int    value;
  } exp_t;

  typedef struct {
    int lock_delay;
    int glitch;
    int exp_release;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ack_count = 0;
  logic prev_ack = 1'b0;
  logic prev_locked = 1'b0;
  exp_t sb_q[$];
  logic [7:0] ack_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .RESET_CYCLES        (RC),
    .LOCK_STABLE_CYCLES  (LSC),
    .LOCK_TIMEOUT_CYCLES (LTO),
    .MAX_RETRIES         (MR),
    .DELAY_INIT          (8'h00)
  ) dut (
    .REFERENCECLK (clk),
    .RESETB       (rst_n),
    .bus          (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic sb_push(input string name, input int v);
    exp_t e;
    e.name  = name;
    e.value = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input int act);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow got %0d want nothing", act);
    end else begin
      e = sb_q.pop_front();
      chk(e.name, act, e.value);
    end
  endtask

  // Count negedges with PLL_RESETB low, starting at the current negedge.
  task automatic low_width(output int w);
    int guard;
    guard = 0;
    w = 0;
    while (bus.PLL_RESETB !== 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    while (bus.PLL_RESETB === 1'b0 && w < 300) begin
      w++;
      @(negedge clk);
    end
  endtask

  task automatic high_width(output int w);
    w = 0;
    while (bus.PLL_RESETB === 1'b1 && w < 300) begin
      w++;
      @(negedge clk);
    end
  endtask

  // Negedges until SYS_RESET drops; optional one-cycle LOCK drop at negedge 'glitch'.
  task automatic wait_release(input int glitch, output int n, output bit extra);
    n = 0;
    extra = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == glitch) bus.PLL_LOCK = 1'b0;
      if (n == glitch + 1) bus.PLL_LOCK = 1'b1;
      if (bus.PLL_RESETB !== 1'b1) extra = 1'b1;
    end while (bus.SYS_RESET !== 1'b0 && n < 300);
  endtask

  task automatic do_reset(input bit check_vals);
    @(negedge clk);
    rst_n = 1'b0;
    bus.PLL_LOCK = 1'b0;
    bus.DELAY_REQ = 1'b0;
    bus.DELAY_DATA = 8'h00;
    #1;
    if (check_vals) begin
      chk("rst_pll_resetb", int'(bus.PLL_RESETB), 0);
      chk("rst_bypass", int'(bus.PLL_BYPASS), 0);
      chk("rst_latch", int'(bus.PLL_LATCHINPUTVALUE), 0);
      chk("rst_delay", int'(bus.PLL_DYNAMICDELAY), 0);
      chk("rst_ack", int'(bus.DELAY_ACK), 0);
      chk("rst_sys_reset", int'(bus.SYS_RESET), 1);
      chk("rst_locked", int'(bus.LOCKED), 0);
      chk("rst_failed", int'(bus.FAILED), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Delay-ack monitor: every ACK must be a single cycle, follow RUN, and carry a queued value.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ack    <= 1'b0;
      prev_locked <= 1'b0;
    end else begin
      if (bus.DELAY_ACK === 1'b1) begin
        ack_count++;
        chk("ack_one_cycle", int'(prev_ack), 0);
        chk("ack_after_run", int'(prev_locked), 1);
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack got delay %0h want no ack", bus.PLL_DYNAMICDELAY);
        end else begin
          chk("ack_delay", int'(bus.PLL_DYNAMICDELAY), int'(ack_q.pop_front()));
        end
      end
      prev_ack    <= bus.DELAY_ACK;
      prev_locked <= bus.LOCKED;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    int  n;
    bit  extra;
    bus.PLL_LOCK   = 1'b0;
    bus.DELAY_REQ  = 1'b0;
    bus.DELAY_DATA = 8'h00;

    // {cycles after PLL_RESETB rise before LOCK, one-cycle drop index, expected release}
    vecs[0] = '{10, -1, 11};
    vecs[1] = '{0,  -1, 11};
    vecs[2] = '{10,  6, 18};
    vecs[3] = '{25,  1, 13};
    vecs[4] = '{5,   8, 20};
    vecs[5] = '{5,   9, 11};

    do_reset(1'b1);

    foreach (vecs[i]) begin
      do_reset(1'b0);
      sb_push("rstb_low", RC);
      low_width(w);
      sb_pop_check(w);
      repeat (vecs[i].lock_delay) @(negedge clk);
      bus.PLL_LOCK = 1'b1;
      sb_push("release", vecs[i].exp_release);
      wait_release(vecs[i].glitch, n, extra);
      sb_pop_check(n);
      chk("no_extra_reset", int'(extra), 0);
      chk("locked", int'(bus.LOCKED), 1);
    end

    // Lock glitches while running.
    do_reset(1'b0);
    sb_push("rstb_low", RC);
    low_width(w);
    sb_pop_check(w);
    bus.PLL_LOCK = 1'b1;
    sb_push("release", 11);
    wait_release(-1, n, extra);
    sb_pop_check(n);
    @(negedge clk);
    bus.PLL_LOCK = 1'b0;
    @(negedge clk);
    bus.PLL_LOCK = 1'b1;
    repeat (6) @(negedge clk);
    chk("glitch1_locked", int'(bus.LOCKED), 1);
    chk("glitch1_sys_reset", int'(bus.SYS_RESET), 0);
    chk("glitch1_pll_resetb", int'(bus.PLL_RESETB), 1);
    @(negedge clk);
    bus.PLL_LOCK = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) bus.PLL_LOCK = 1'b1;
    end while (bus.SYS_RESET !== 1'b1 && n < 50);
    sb_push("loss_latency", 4);
    sb_pop_check(n);
    chk("loss_locked", int'(bus.LOCKED), 0);
    sb_push("loss_rstb_low", RC);
    low_width(w);
    sb_pop_check(w);
    sb_push("relock", 9);
    wait_release(-1, n, extra);
    sb_pop_check(n);
    chk("relock_locked", int'(bus.LOCKED), 1);

    // Delay update requested during STABLE.
    do_reset(1'b0);
    sb_push("rstb_low", RC);
    low_width(w);
    sb_pop_check(w);
    bus.PLL_LOCK = 1'b1;
    repeat (4) @(negedge clk);
    bus.DELAY_DATA = 8'hA5;
    bus.DELAY_REQ  = 1'b1;
    ack_q.push_back(8'hA5);
    n = 0;
    while (bus.DELAY_ACK !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    sb_push("ack_latency", 8);
    sb_pop_check(n);
    chk("ack_sys_reset", int'(bus.SYS_RESET), 1);
    bus.DELAY_REQ = 1'b0;
    bus.PLL_LOCK  = 1'b0;
    sb_push("delay_rstb_low", RC);
    low_width(w);
    sb_pop_check(w);
    sb_push("delay_wait", LTO);
    high_width(w);
    sb_pop_check(w);
    sb_push("retry_rstb_low", RC);
    low_width(w);
    sb_pop_check(w);
    bus.PLL_LOCK = 1'b1;
    repeat (6) @(negedge clk);
    chk("delay_kept", int'(bus.PLL_DYNAMICDELAY), 8'hA5);
    chk("stable_sys_reset", int'(bus.SYS_RESET), 1);

    // Reset mid-STABLE after a retry, then LOCK never rises.
    do_reset(1'b1);
    sb_push("nolock_low1", RC);
    low_width(w);
    sb_pop_check(w);
    sb_push("nolock_wait1", LTO);
    high_width(w);
    sb_pop_check(w);
    sb_push("nolock_low2", RC);
    low_width(w);
    sb_pop_check(w);
    sb_push("nolock_wait2", LTO);
    high_width(w);
    sb_pop_check(w);
    chk("fail_failed", int'(bus.FAILED), 1);
    chk("fail_bypass", int'(bus.PLL_BYPASS), 1);
    chk("fail_sys_reset", int'(bus.SYS_RESET), 0);
    chk("fail_locked", int'(bus.LOCKED), 0);
    chk("fail_pll_resetb", int'(bus.PLL_RESETB), 0);

    // FAIL is sticky and never acknowledges a delay request.
    bus.PLL_LOCK   = 1'b1;
    bus.DELAY_DATA = 8'h3C;
    bus.DELAY_REQ  = 1'b1;
    repeat (30) @(negedge clk);
    chk("fail_sticky", int'(bus.FAILED), 1);
    chk("fail_bypass_held", int'(bus.PLL_BYPASS), 1);
    chk("fail_delay", int'(bus.PLL_DYNAMICDELAY), 0);
    chk("ack_total", ack_count, 1);
    chk("sb_empty", sb_q.size(), 0);
    chk("ackq_empty", ack_q.size(), 0);

    do_reset(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
